// File: rtl/ifft_r2_stage.sv
// ifft_r2_stage: pipelined radix-2 DIF butterfly with IFFT twiddle rotation, 6-cycle latency.
// Define IFFT_ROUND_EN for round-half-up scaling of the rotated difference; default build truncates.
module ifft_r2_stage (
    input  logic               clk,
    input  logic               rst,
    input  logic        [6:0]  twsel,
    input  logic signed [35:0] di1r,
    input  logic signed [35:0] di1i,
    input  logic signed [35:0] di2r,
    input  logic signed [35:0] di2i,
    output logic signed [35:0] do1r,
    output logic signed [35:0] do1i,
    output logic signed [35:0] do2r,
    output logic signed [35:0] do2i
);
`ifdef IFFT_ROUND_EN
    localparam logic signed [54:0] RND = 55'sd32768;
`else
    localparam logic signed [54:0] RND = 55'sd0;
`endif
    // Quarter wave of round(65536*cos(pi*m/64)); the full 128-entry circle is folded onto it.
    localparam logic [16:0] QCOS [0:32] = '{
        17'd65536, 17'd65457, 17'd65220, 17'd64827, 17'd64277, 17'd63572, 17'd62714,
        17'd61705, 17'd60547, 17'd59244, 17'd57798, 17'd56212, 17'd54491, 17'd52639,
        17'd50660, 17'd48559, 17'd46341, 17'd44011, 17'd41576, 17'd39040, 17'd36410,
        17'd33692, 17'd30893, 17'd28020, 17'd25080, 17'd22078, 17'd19024, 17'd15924,
        17'd12785, 17'd9616,  17'd6424,  17'd3216,  17'd0
    };

    function automatic logic signed [17:0] tw_cos(input logic [6:0] k);
        logic [5:0] m;
        m = k <= 7'd32 ? k[5:0] : k <= 7'd64 ? 6'(7'd64 - k) : k <= 7'd96 ? 6'(k - 7'd64) : 6'(7'd0 - k);
        return (k > 7'd32 && k <= 7'd96) ? -$signed({1'b0, QCOS[m]}) : $signed({1'b0, QCOS[m]});
    endfunction

    logic signed [35:0] b1r_d, b1i_d, b2r_d, b2i_d, b1r_q, b1i_q, b2r_q, b2i_q;
    logic        [6:0]  tw_q;
    logic signed [35:0] u2r_q, u2i_q, u3r_q, u3i_q, u4r_q, u4i_q, u5r_q, u5i_q;
    logic signed [35:0] ar_q, ai_q;
    logic signed [17:0] wr_d, wi_d, wr_q, wi_q;
    logic signed [53:0] rr_d, ii_d, ri_d, ir_d, rr_q, ii_q, ri_q, ir_q;
    logic signed [54:0] pr_d, pi_d, pr_q, pi_q;
    logic signed [35:0] sr_d, si_d, sr_q, si_q;

    always_comb begin
        b1r_d = di1r + di2r;
        b1i_d = di1i + di2i;
        b2r_d = di1r - di2r;
        b2i_d = di1i - di2i;
        wr_d  = tw_cos(tw_q);
        wi_d  = tw_cos(tw_q - 7'd32);
        rr_d  = 54'(ar_q) * 54'(wr_q);
        ii_d  = 54'(ai_q) * 54'(wi_q);
        ri_d  = 54'(ar_q) * 54'(wi_q);
        ir_d  = 54'(ai_q) * 54'(wr_q);
        pr_d  = 55'(rr_q) - 55'(ii_q);
        pi_d  = 55'(ri_q) + 55'(ir_q);
        sr_d  = 36'((pr_q + RND) >>> 16);
        si_d  = 36'((pi_q + RND) >>> 16);
    end

    always_ff @(posedge clk) begin
        b1r_q <= rst ? '0 : b1r_d;
        b1i_q <= rst ? '0 : b1i_d;
        b2r_q <= rst ? '0 : b2r_d;
        b2i_q <= rst ? '0 : b2i_d;
        tw_q  <= rst ? '0 : twsel;
        u2r_q <= rst ? '0 : b1r_q;
        u2i_q <= rst ? '0 : b1i_q;
        ar_q  <= rst ? '0 : b2r_q;
        ai_q  <= rst ? '0 : b2i_q;
        wr_q  <= rst ? '0 : wr_d;
        wi_q  <= rst ? '0 : wi_d;
        u3r_q <= rst ? '0 : u2r_q;
        u3i_q <= rst ? '0 : u2i_q;
        rr_q  <= rst ? '0 : rr_d;
        ii_q  <= rst ? '0 : ii_d;
        ri_q  <= rst ? '0 : ri_d;
        ir_q  <= rst ? '0 : ir_d;
        u4r_q <= rst ? '0 : u3r_q;
        u4i_q <= rst ? '0 : u3i_q;
        pr_q  <= rst ? '0 : pr_d;
        pi_q  <= rst ? '0 : pi_d;
        u5r_q <= rst ? '0 : u4r_q;
        u5i_q <= rst ? '0 : u4i_q;
        sr_q  <= rst ? '0 : sr_d;
        si_q  <= rst ? '0 : si_d;
        do1r  <= rst ? '0 : u5r_q;
        do1i  <= rst ? '0 : u5i_q;
        do2r  <= rst ? '0 : sr_q;
        do2i  <= rst ? '0 : si_q;
    end
endmodule

// File: tb/tb_ifft_r2_stage.sv
// tb_ifft_r2_stage: scoreboard bench for ifft_r2_stage; expectations are queued at issue time
// and popped by a monitor when their output cycle arrives.
module tb_ifft_r2_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] twsel = 7'd9;
    logic signed [35:0] di1r = 36'sd123, di1i = -36'sd77, di2r = 36'sd45, di2i = 36'sd6;
    logic signed [35:0] do1r, do1i, do2r, do2i;
    int cyc = 0, since_rst = 0, errors = 0, checks = 0;

    typedef struct {
        int due;
        logic signed [35:0] e1r, e1i, e2r, e2i;
    } exp_t;
    exp_t sb[$];

    ifft_r2_stage dut (
        .clk(clk), .rst(rst), .twsel(twsel),
        .di1r(di1r), .di1i(di1i), .di2r(di2r), .di2i(di2i),
        .do1r(do1r), .do1i(do1i), .do2r(do2r), .do2i(do2i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        since_rst <= rst ? 0 : (since_rst > 99 ? since_rst : since_rst + 1);
    end

    function automatic logic signed [35:0] w36(input longint x);
        return x[35:0];
    endfunction

    function automatic longint rnd(input real x);
        return x < 0.0 ? -longint'($rtoi(-x + 0.5)) : longint'($rtoi(x + 0.5));
    endfunction

    function automatic logic signed [35:0] rnd36();
        return 36'({$urandom(), $urandom()});
    endfunction

    task automatic model(input logic [6:0] k, input logic signed [35:0] a1r, a1i, a2r, a2i,
                         output logic signed [35:0] e1r, e1i, e2r, e2i);
        longint br, bi, wr, wi, pr, pi;
        real ang;
        ang = 2.0 * 3.141592653589793 * real'(k) / 128.0;
        wr = rnd(65536.0 * $cos(ang));
        wi = rnd(65536.0 * $sin(ang));
        e1r = w36(longint'(a1r) + longint'(a2r));
        e1i = w36(longint'(a1i) + longint'(a2i));
        br = longint'(w36(longint'(a1r) - longint'(a2r)));
        bi = longint'(w36(longint'(a1i) - longint'(a2i)));
        pr = br * wr - bi * wi;
        pi = br * wi + bi * wr;
`ifdef IFFT_ROUND_EN
        pr = pr + 32768;
        pi = pi + 32768;
`endif
        e2r = w36(pr >>> 16);
        e2i = w36(pi >>> 16);
    endtask

    task automatic check(input string nm, input logic signed [35:0] e1r, e1i, e2r, e2i);
        checks++;
        if (do1r !== e1r || do1i !== e1i || do2r !== e2r || do2i !== e2i) begin
            errors++;
            $display("FAIL %s cyc=%0d got do1=(%0d,%0d) do2=(%0d,%0d) expected do1=(%0d,%0d) do2=(%0d,%0d)",
                     nm, cyc, do1r, do1i, do2r, do2i, e1r, e1i, e2r, e2i);
        end
    endtask

    // Any reset edge within the last six edges means the output register holds flushed zeros.
    always @(negedge clk) begin
        if (since_rst <= 5) check("rst_flush", '0, '0, '0, '0);
        else if (sb.size() != 0 && sb[0].due == cyc) check("vector", sb[0].e1r, sb[0].e1i, sb[0].e2r, sb[0].e2i);
        if (sb.size() != 0 && sb[0].due == cyc) void'(sb.pop_front());
    end

    task automatic drive(input bit r, input logic [6:0] k, input logic signed [35:0] a1r, a1i, a2r, a2i,
                         input logic signed [35:0] e1r, e1i, e2r, e2i);
        @(negedge clk);
        rst = r;
        twsel = k;
        di1r = a1r;
        di1i = a1i;
        di2r = a2r;
        di2i = a2i;
        if (!r) sb.push_back('{cyc + 6, e1r, e1i, e2r, e2i});
    endtask

    task automatic drive_m(input bit r, input logic [6:0] k, input logic signed [35:0] a1r, a1i, a2r, a2i);
        logic signed [35:0] e1r, e1i, e2r, e2i;
        model(k, a1r, a1i, a2r, a2i, e1r, e1i, e2r, e2i);
        drive(r, k, a1r, a1i, a2r, a2i, e1r, e1i, e2r, e2i);
    endtask

    initial begin
        repeat (2) drive(1'b1, 7'd9, 36'sd123, -36'sd77, 36'sd45, 36'sd6, '0, '0, '0, '0);
        drive(1'b0, 7'd0,  36'sd100, -36'sd50, 36'sd30, 36'sd20, 36'sd130, -36'sd30, 36'sd70, -36'sd70);
        drive(1'b0, 7'd32, 36'sd5, 36'sd0, 36'sd1, 36'sd2, 36'sd6, 36'sd2, 36'sd2, 36'sd4);
        drive(1'b0, 7'd64, 36'sd5, 36'sd0, 36'sd1, 36'sd2, 36'sd6, 36'sd2, -36'sd4, 36'sd2);
        drive(1'b0, 7'd96, 36'sd5, 36'sd0, 36'sd1, 36'sd2, 36'sd6, 36'sd2, -36'sd2, -36'sd4);
        drive(1'b0, 7'd16, 36'sd65536, 36'sd0, 36'sd0, 36'sd0, 36'sd65536, 36'sd0, 36'sd46341, 36'sd46341);
        drive(1'b0, 7'd0,  36'sh7FFFFFFFF, 36'sd0, 36'sd1, 36'sd0, 36'sh800000000, 36'sd0, 36'sh7FFFFFFFE, 36'sd0);
        for (int n = 0; n < 32; n++)
            drive_m(n == 16, 7'($urandom_range(0, 127)), rnd36(), rnd36(), rnd36(), rnd36());
        for (int k = 0; k < 128; k++)
            drive_m(1'b0, 7'(k), 36'sd700000, -36'sd123456, -36'sd300000, 36'sd176544);
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
